// File: rtl/dec_onehot2bin_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : dec_onehot2bin_reg_if
//  Description : Streaming bus for the one-hot to binary decoder. Carries the
//                upstream valid/ready/data, the downstream valid/ready/data
//                with error flag, and the error-counter clear/count pair.
//  Revision    : 1.0  initial release
// ============================================================================
interface dec_onehot2bin_reg_if #(
    parameter int N         = 15,
    parameter int W         = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0]         in;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         out;
    logic                 out_err;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_cnt;

    // Traffic source/sink side (drives beats in, accepts beats out)
    modport master (
        output in_valid, in, out_ready, err_clr,
        input  in_ready, out_valid, out, out_err, err_cnt
    );

    // Decoder side
    modport slave (
        input  in_valid, in, out_ready, err_clr,
        output in_ready, out_valid, out, out_err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dec_onehot2bin_reg.sv
`default_nettype none
// ============================================================================
//  Module      : dec_onehot2bin_reg
//  Description : Registered one-hot to binary decoder with a valid/ready
//                handshake and 2-entry skid buffer (output register + skid
//                register). Malformed vectors (zero-hot or multi-hot) decode
//                to all-ones with an error flag and bump a saturating counter.
//  Revision    : 1.0  initial release
// ============================================================================
module dec_onehot2bin_reg #(
    parameter int N         = 15,
    parameter int W         = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dec_onehot2bin_reg_if.slave   bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [ERR_CNT_W-1:0] c_err_max = {ERR_CNT_W{1'b1}};

    state_t               r_state;
    state_t               w_next_state;
    logic [W-1:0]         r_out;
    logic                 r_out_err;
    logic                 r_out_valid;
    logic [W-1:0]         r_skid;
    logic                 r_skid_err;
    logic                 r_in_ready;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic                 w_accept;
    logic                 w_emit;
    logic                 w_load_out_in;
    logic                 w_load_out_skid;
    logic                 w_load_skid;
    logic [W-1:0]         w_idx;
    logic                 w_malformed;
    logic [W-1:0]         w_dec;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_emit   = r_out_valid && bus.out_ready;

    // Decode: OR together the indices of all set bits, then override with
    // all-ones when the vector is not exactly one-hot so no malformed input
    // can alias onto a legal index.
    always_comb begin
        w_idx       = '0;
        w_malformed = (bus.in == '0) || ((bus.in & (bus.in - N'(1))) != '0);
        for (int i = 0; i < N; i++) begin
            if (bus.in[i]) begin
                w_idx = w_idx | W'(i);
            end
        end
        w_dec = w_malformed ? {W{1'b1}} : w_idx;
    end

    // Buffer occupancy register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next occupancy and datapath load selects
    always_comb begin
        w_next_state    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_load_out_in = 1'b1;
                    w_next_state  = S_ONE;
                end
            end
            S_ONE: begin
                if (w_accept && w_emit) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    w_load_skid  = 1'b1;
                    w_next_state = S_FULL;
                end else if (w_emit) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only the emit path can fire
                if (w_emit) begin
                    w_load_out_skid = 1'b1;
                    w_next_state    = S_ONE;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    // Output/skid registers; flags derived from next occupancy keep
    // in_ready free of any combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_err   <= 1'b0;
            r_skid      <= '0;
            r_skid_err  <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            if (w_load_out_in) begin
                r_out     <= w_dec;
                r_out_err <= w_malformed;
            end else if (w_load_out_skid) begin
                r_out     <= r_skid;
                r_out_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid     <= w_dec;
                r_skid_err <= w_malformed;
            end
            r_out_valid <= (w_next_state != S_EMPTY);
            r_in_ready  <= (w_next_state != S_FULL);
        end
    end

    // Saturating malformed-beat counter, counted at accept time
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (bus.err_clr) begin
            r_err_cnt <= (w_accept && w_malformed) ? ERR_CNT_W'(1) : '0;
        end else if (w_accept && w_malformed && (r_err_cnt != c_err_max)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.out_err   = r_out_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dec_onehot2bin_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dec_onehot2bin_reg
//  Description : Scoreboard bench for dec_onehot2bin_reg. Stimulus pushes the
//                hand-computed {err, index} for every accepted beat; a monitor
//                pops and compares on each emitted beat and checks hold
//                stability under backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dec_onehot2bin_reg;

    localparam int N         = 15;
    localparam int W         = 4;
    localparam int ERR_CNT_W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [W:0] sb[$];

    dec_onehot2bin_reg_if #(.N(N), .W(W), .ERR_CNT_W(ERR_CNT_W)) bus ();

    dec_onehot2bin_reg #(.N(N), .W(W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and wait (bounded) until it is accepted
    task automatic send(input logic [N-1:0] v, input logic [W-1:0] exp_idx, input logic exp_err);
        int waited;
        waited       = 0;
        bus.in_valid = 1'b1;
        bus.in       = v;
        while (!bus.in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for in=%0h", v);
        end else begin
            sb.push_back({exp_err, exp_idx});
            tick();
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in       = '0;
    endtask

    // Monitor: compare emitted beats against the scoreboard; check that a
    // stalled beat holds its value.
    logic           prev_stall;
    logic [W-1:0]   prev_out;
    logic           prev_err;
    logic [W:0]     exp_beat;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && bus.out_valid) begin
                chk("hold_out", 32'(bus.out), 32'(prev_out));
                chk("hold_err", 32'(bus.out_err), 32'(prev_err));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got out=%0h err=%0b expected no beat",
                             bus.out, bus.out_err);
                end else begin
                    exp_beat = sb.pop_front();
                    chk("beat_out", 32'(bus.out), 32'(exp_beat[W-1:0]));
                    chk("beat_err", 32'(bus.out_err), 32'(exp_beat[W]));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = bus.out;
            prev_err   = bus.out_err;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        prev_stall    = 1'b0;
        rst           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 15'h0004;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;

        // 1: reset with a beat presented; it must be dropped
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_err_cnt", 32'(bus.err_cnt), 0);
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_out_err", 32'(bus.out_err), 0);
        rst = 1'b1;
        idle();
        tick();
        chk("rst_dropped", 32'(bus.out_valid), 0);

        // 2: full-rate sweep of every legal one-hot vector
        for (int i = 0; i < N; i++) begin
            send(N'(1) << i, W'(i), 1'b0);
            chk("sweep_no_bubble", 32'(bus.out_valid), 1);
        end
        idle();
        tick();
        tick();
        chk("sweep_err_cnt", 32'(bus.err_cnt), 0);
        chk("sweep_drained", 32'(bus.out_valid), 0);

        // 3: malformed vectors
        send(15'h0000, 4'hF, 1'b1);
        send(15'h0011, 4'hF, 1'b1);
        idle();
        tick();
        chk("malformed_err_cnt", 32'(bus.err_cnt), 2);

        // 4: backpressure fills the skid buffer
        bus.out_ready = 1'b0;
        send(15'h0008, 4'd3, 1'b0);
        chk("bp_ready_one", 32'(bus.in_ready), 1);
        send(15'h0080, 4'd7, 1'b0);
        chk("bp_ready_full", 32'(bus.in_ready), 0);
        chk("bp_out_head", 32'(bus.out), 3);
        bus.in_valid = 1'b1;
        bus.in       = 15'h0200;
        tick();
        tick();
        chk("bp_still_full", 32'(bus.in_ready), 0);
        chk("bp_held", 32'(bus.out), 3);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_ready_back", 32'(bus.in_ready), 1);
        chk("bp_second", 32'(bus.out), 7);
        send(15'h0200, 4'd9, 1'b0);
        idle();
        tick();
        tick();

        // 5: saturation and clear
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr_alone_a", 32'(bus.err_cnt), 0);
        for (int k = 1; k <= 260; k++) begin
            send(15'h0000, 4'hF, 1'b1);
            if (k == 254) chk("sat_254", 32'(bus.err_cnt), 254);
            if (k == 255) chk("sat_255", 32'(bus.err_cnt), 255);
        end
        idle();
        tick();
        chk("sat_hold", 32'(bus.err_cnt), 255);
        bus.err_clr = 1'b1;
        send(15'h0003, 4'hF, 1'b1);
        bus.err_clr = 1'b0;
        idle();
        chk("clr_with_err", 32'(bus.err_cnt), 1);
        tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("clr_alone_b", 32'(bus.err_cnt), 0);
        tick();

        // 6: reset while full under backpressure
        bus.out_ready = 1'b0;
        send(15'h0000, 4'hF, 1'b1);
        send(15'h0004, 4'd2, 1'b0);
        idle();
        chk("mid_full", 32'(bus.in_ready), 0);
        chk("mid_err_cnt", 32'(bus.err_cnt), 1);
        rst = 1'b0;
        tick();
        sb.delete();
        rst = 1'b1;
        chk("mid_out_valid", 32'(bus.out_valid), 0);
        chk("mid_in_ready", 32'(bus.in_ready), 1);
        chk("mid_err_clr", 32'(bus.err_cnt), 0);
        bus.out_ready = 1'b1;
        send(15'h0020, 4'd5, 1'b0);
        idle();
        chk("mid_after", 32'(bus.out), 5);
        tick();
        tick();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
